memory_request_tracker: RTL and testbench
=========================================

MEMORY_REQUEST_TRACKER -- requirements
Module: memory_request_tracker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data field width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, cache address width in bits.
REQ-003 SHALL have parameter NUM_BUFFERS, default 9, descriptor base addresses (2..16).
REQ-004 SHALL have parameter NUM_FIELDS, default 4, packet data fields (>=2).
REQ-005 SHALL have parameter DEPTH, default 16, outstanding-read table entries (power of 2); TAG_W = clog2(DEPTH).
REQ-006 SHALL have parameter META_W, default 128, opaque packed meta width.
REQ-007 SHALL have the following ports:
- ap_clk  in  1  clock; one clock, all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  load base table (one-cycle pulse).
- cfg_base  in  NUM_BUFFERS*ADDR_W  base addresses; slice k is buffer k.
- drain_req  in  1  pulse; stop accepting requests, finish outstanding reads.
- drain_done  out  1  one-cycle pulse when drain completes.
- req_valid / req_ready  in/out  1  request handshake.
- req_cmd_write  in  1  1 = write, 0 = read.
- req_id_buffer  in  NUM_BUFFERS-1  one-hot buffer select.
- req_offset  in  DATA_W  address offset.
- req_meta  in  META_W  meta to carry to the response.
- req_data  in  NUM_FIELDS*DATA_W  fields; field 0 = write data.
- cache_req_valid / cache_req_ready  out/in  1  cache request handshake.
- cache_req_addr  out  ADDR_W  target address.
- cache_req_wdata  out  DATA_W  write data.
- cache_req_wstrb  out  DATA_W/8  write strobes.
- cache_req_tag  out  TAG_W  read tag.
- cache_rsp_valid / cache_rsp_ready  in/out  1  cache response handshake.
- cache_rsp_tag  in  TAG_W  returned tag.
- cache_rsp_rdata  in  DATA_W  read data.
- mem_rsp_valid / mem_rsp_ready  out/in  1  response packet handshake.
- mem_rsp_meta  out  META_W  stored meta.
- mem_rsp_data  out  NUM_FIELDS*DATA_W  shifted fields.
- outstanding  out  TAG_W+1  live read count.
- err_sticky  out  1  protocol error seen; cleared only by reset.

Function
REQ-008 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN on cfg_valid (base table latched).
- RUN->DRAIN on drain_req.
- DRAIN->IDLE when outstanding==0 and mem_rsp_valid==0; drain_done pulses that same cycle.
REQ-009 In RUN, cfg_valid SHALL be ignored and set err_sticky; in IDLE and DRAIN, drain_req is ignored.
REQ-010 req_ready = (state==RUN) & !full & (!cache_req_valid | cache_req_ready), where full means outstanding==DEPTH.
REQ-011 Base select: exactly one bit k set in req_id_buffer -> base k+1; zero bits or multiple bits -> base 0.
REQ-012 cache_req_addr = base + zero-extended req_offset, truncated to ADDR_W (wrap-around, no error).
REQ-013 cache_req_wdata = field 0. cache_req_wstrb = all ones for a write, all zeros for a read.
REQ-014 Cache request output is a single register stage: loaded one cycle after the req handshake, held stable until cache_req_ready; back-to-back accepts at full throughput.
REQ-015 A read allocates the lowest-index free tag at the req handshake and stores req_meta and fields 0..NUM_FIELDS-2 under it. A write allocates nothing, gets no response, and drives cache_req_tag=0.
REQ-016 cache_rsp_ready = !mem_rsp_valid | mem_rsp_ready.
REQ-017 On a cache_rsp handshake with an allocated tag, next cycle the tracker SHALL present:
- mem_rsp_meta = stored meta;
- mem_rsp_data field 0 = rdata;
- field i = stored field i-1 for i >= 1.
The tag is freed in the same cycle.
REQ-018 A response with an unallocated tag SHALL be consumed, produce no output, and set err_sticky.
REQ-019 Simultaneous allocate and free: outstanding is unchanged; a freed tag is not reallocatable until the next cycle.
REQ-020 Responses may return out of order; output order SHALL follow response arrival order.

Reset
REQ-021 ap_rst_n low SHALL asynchronously force:
- state to IDLE and all tags free;
- outstanding to 0;
- cache_req_valid, mem_rsp_valid, drain_done, err_sticky and req_ready to 0;
- cache_rsp_ready to 1;
- base table to 0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight entries; release is synchronised to ap_clk and the block requires cfg_valid before accepting requests.

Verification
REQ-023 cfg base2=0x1000, read id_buffer=0b10 offset 0x20 -> cache_req_addr 0x1020, wstrb 0, tag 0.
REQ-024 Write id_buffer=0b101 offset 4 data 0xAB -> addr = base0+4, wstrb 0xF, wdata 0xAB, outstanding stays 0.
REQ-025 16 reads with cache_rsp_valid held low -> outstanding 16 and req_ready 0; one response with tag 5 -> outstanding 15, next read gets tag 5.
REQ-026 Read with fields {1,2,3,4}, response rdata 0x99 -> mem_rsp_data fields {0x99,1,2,3} and meta echoed.
REQ-027 Responses returned for tags 2,0,1 with mem_rsp_ready low for 3 cycles -> no loss, outputs in order 2,0,1, cache_rsp_ready low while stalled.
REQ-028 drain_req with 3 reads outstanding -> req_ready 0; drain_done pulses once after the last response is taken; bogus tag 7 -> err_sticky 1.

Source files
------------

// File: rtl/memory_request_tracker_if.sv
// Bundle of every handshake, bus, configuration and status signal of the
// memory request tracker. The "slave" modport is the tracker's view. The
// "master" modport is the environment, which plays the requester, the cache
// and the response consumer.
interface memory_request_tracker_if #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 64,
  parameter int NUM_BUFFERS = 9,
  parameter int NUM_FIELDS  = 4,
  parameter int DEPTH       = 16,
  parameter int META_W      = 128
);
  localparam int TAG_W = $clog2(DEPTH);

  // configuration and drain control
  logic                          cfg_valid;
  logic [NUM_BUFFERS*ADDR_W-1:0] cfg_base;
  logic                          drain_req;
  logic                          drain_done;

  // incoming request
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_cmd_write;
  logic [NUM_BUFFERS-2:0]        req_id_buffer;
  logic [DATA_W-1:0]             req_offset;
  logic [META_W-1:0]             req_meta;
  logic [NUM_FIELDS*DATA_W-1:0]  req_data;

  // request toward the cache
  logic                          cache_req_valid;
  logic                          cache_req_ready;
  logic [ADDR_W-1:0]             cache_req_addr;
  logic [DATA_W-1:0]             cache_req_wdata;
  logic [DATA_W/8-1:0]           cache_req_wstrb;
  logic [TAG_W-1:0]              cache_req_tag;

  // response from the cache
  logic                          cache_rsp_valid;
  logic                          cache_rsp_ready;
  logic [TAG_W-1:0]              cache_rsp_tag;
  logic [DATA_W-1:0]             cache_rsp_rdata;

  // outgoing response packet
  logic                          mem_rsp_valid;
  logic                          mem_rsp_ready;
  logic [META_W-1:0]             mem_rsp_meta;
  logic [NUM_FIELDS*DATA_W-1:0]  mem_rsp_data;

  // status
  logic [TAG_W:0]                outstanding;
  logic                          err_sticky;

  modport master (
    output cfg_valid, cfg_base, drain_req,
    output req_valid, req_cmd_write, req_id_buffer, req_offset, req_meta, req_data,
    output cache_req_ready,
    output cache_rsp_valid, cache_rsp_tag, cache_rsp_rdata,
    output mem_rsp_ready,
    input  drain_done, req_ready,
    input  cache_req_valid, cache_req_addr, cache_req_wdata, cache_req_wstrb, cache_req_tag,
    input  cache_rsp_ready,
    input  mem_rsp_valid, mem_rsp_meta, mem_rsp_data,
    input  outstanding, err_sticky
  );

  modport slave (
    input  cfg_valid, cfg_base, drain_req,
    input  req_valid, req_cmd_write, req_id_buffer, req_offset, req_meta, req_data,
    input  cache_req_ready,
    input  cache_rsp_valid, cache_rsp_tag, cache_rsp_rdata,
    input  mem_rsp_ready,
    output drain_done, req_ready,
    output cache_req_valid, cache_req_addr, cache_req_wdata, cache_req_wstrb, cache_req_tag,
    output cache_rsp_ready,
    output mem_rsp_valid, mem_rsp_meta, mem_rsp_data,
    output outstanding, err_sticky
  );
endinterface

// File: rtl/memory_request_tracker.sv
// Memory request tracker. It turns buffer-relative requests into absolute
// cache requests. Each read gets a tag, and the tracker stores the read's meta
// and payload fields under that tag. When the cache response for the tag comes
// back, the tracker rebuilds the response packet from the stored data.
// Responses may come back out of order; output packets follow arrival order.
module memory_request_tracker #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 64,
  parameter int NUM_BUFFERS = 9,
  parameter int NUM_FIELDS  = 4,
  parameter int DEPTH       = 16,
  parameter int META_W      = 128
) (
  input logic                     ap_clk,
  input logic                     ap_rst_n,
  memory_request_tracker_if.slave bus
);
  localparam int TAG_W  = $clog2(DEPTH);
  localparam int CNT_W  = TAG_W + 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int FLD_W  = (NUM_FIELDS - 1) * DATA_W;
  localparam int SEL_W  = $clog2(NUM_BUFFERS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                cfg_load, cfg_err, drain_done;

  logic [1:0]          rst_sync_q;
  logic                rst_n;

  logic [ADDR_W-1:0]   base_q [NUM_BUFFERS];
  logic [SEL_W-1:0]    base_sel;
  logic [ADDR_W-1:0]   req_addr;

  logic [DEPTH-1:0]    alloc_q;
  logic [META_W-1:0]   meta_q   [DEPTH];
  logic [FLD_W-1:0]    fields_q [DEPTH];
  logic [CNT_W-1:0]    outstanding_q;
  logic [TAG_W-1:0]    free_tag;

  logic                cache_req_valid_q;
  logic [ADDR_W-1:0]   cache_req_addr_q;
  logic [DATA_W-1:0]   cache_req_wdata_q;
  logic [STRB_W-1:0]   cache_req_wstrb_q;
  logic [TAG_W-1:0]    cache_req_tag_q;

  logic                mem_rsp_valid_q;
  logic [META_W-1:0]   mem_rsp_meta_q;
  logic [NUM_FIELDS*DATA_W-1:0] mem_rsp_data_q;
  logic                err_q;

  logic                full, req_fire, do_alloc, rsp_fire, rsp_hit, rsp_miss;

  // Reset asserts asynchronously and is released on a clock edge.
  // NOTE: sequential state always uses <= so that every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Handshake qualifiers.
  assign full      = (outstanding_q == CNT_W'(DEPTH));
  assign bus.req_ready = (state_q == ST_RUN) && !full && (!cache_req_valid_q || bus.cache_req_ready);
  assign req_fire  = bus.req_valid && bus.req_ready;
  assign do_alloc  = req_fire && !bus.req_cmd_write;
  assign bus.cache_rsp_ready = !mem_rsp_valid_q || bus.mem_rsp_ready;
  assign rsp_fire  = bus.cache_rsp_valid && bus.cache_rsp_ready;
  assign rsp_hit   = rsp_fire && alloc_q[bus.cache_rsp_tag];
  assign rsp_miss  = rsp_fire && !alloc_q[bus.cache_rsp_tag];

  // Mode control: configure, run, then drain until nothing is in flight.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes.
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cfg_load   = 1'b0;
    cfg_err    = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          cfg_load = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.cfg_valid) cfg_err = 1'b1;
        if (bus.drain_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_q == '0 && !mem_rsp_valid_q) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign bus.drain_done = drain_done;

  // Base address table, reloaded on each accepted configuration.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BUFFERS; k++) base_q[k] <= '0;
    end else if (cfg_load) begin
      for (int k = 0; k < NUM_BUFFERS; k++) base_q[k] <= bus.cfg_base[k*ADDR_W +: ADDR_W];
    end
  end

  // A one-hot buffer id selects base k+1; none or several bits select base 0.
  always_comb begin
    logic seen, multi;
    seen     = 1'b0;
    multi    = 1'b0;
    base_sel = '0;
    for (int k = 0; k < NUM_BUFFERS - 1; k++) begin
      if (bus.req_id_buffer[k]) begin
        if (seen) multi = 1'b1;
        seen     = 1'b1;
        base_sel = SEL_W'(k + 1);
      end
    end
    if (!seen || multi) base_sel = '0;
  end
  assign req_addr = base_q[base_sel] + ADDR_W'(bus.req_offset);

  // Lowest-index free tag; the downward scan lets the lowest index win.
  always_comb begin
    free_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!alloc_q[i]) free_tag = TAG_W'(i);
    end
  end

  // Single-register cache request stage, held until the cache takes it.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_req_valid_q <= 1'b0;
      cache_req_addr_q  <= '0;
      cache_req_wdata_q <= '0;
      cache_req_wstrb_q <= '0;
      cache_req_tag_q   <= '0;
    end else if (req_fire) begin
      cache_req_valid_q <= 1'b1;
      cache_req_addr_q  <= req_addr;
      cache_req_wdata_q <= bus.req_data[DATA_W-1:0];
      cache_req_wstrb_q <= {STRB_W{bus.req_cmd_write}};
      cache_req_tag_q   <= bus.req_cmd_write ? '0 : free_tag;
    end else if (bus.cache_req_ready) begin
      cache_req_valid_q <= 1'b0;
    end
  end
  assign bus.cache_req_valid = cache_req_valid_q;
  assign bus.cache_req_addr  = cache_req_addr_q;
  assign bus.cache_req_wdata = cache_req_wdata_q;
  assign bus.cache_req_wstrb = cache_req_wstrb_q;
  assign bus.cache_req_tag   = cache_req_tag_q;

  // Tag ownership and the live read count. A tag freed this cycle is still
  // marked busy for this cycle's allocation, so it cannot be reused until the next cycle.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (rsp_hit)  alloc_q[bus.cache_rsp_tag] <= 1'b0;
      if (do_alloc) alloc_q[free_tag]          <= 1'b1;
      unique case ({do_alloc, rsp_hit})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end
  assign bus.outstanding = outstanding_q;

  // Per-tag payload storage, written when a read allocates its tag.
  // NOTE: payload RAM has no reset; alloc_q guards every read of it, so stale contents are never visible.
  always_ff @(posedge ap_clk) begin
    if (do_alloc) begin
      meta_q[free_tag]   <= bus.req_meta;
      fields_q[free_tag] <= bus.req_data[FLD_W-1:0];
    end
  end

  // Response packet register: rdata becomes field 0 and the stored fields shift up by one.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rsp_valid_q <= 1'b0;
      mem_rsp_meta_q  <= '0;
      mem_rsp_data_q  <= '0;
    end else if (rsp_hit) begin
      mem_rsp_valid_q <= 1'b1;
      mem_rsp_meta_q  <= meta_q[bus.cache_rsp_tag];
      mem_rsp_data_q  <= {fields_q[bus.cache_rsp_tag], bus.cache_rsp_rdata};
    end else if (bus.mem_rsp_ready) begin
      mem_rsp_valid_q <= 1'b0;
    end
  end
  assign bus.mem_rsp_valid = mem_rsp_valid_q;
  assign bus.mem_rsp_meta  = mem_rsp_meta_q;
  assign bus.mem_rsp_data  = mem_rsp_data_q;

  // Sticky protocol error: unknown response tag, or reconfiguration while running.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (rsp_miss || cfg_err) err_q <= 1'b1;
  end
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_memory_request_tracker.sv
// Directed self-checking bench for memory_request_tracker (default parameters).
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at the same point.
module tb_memory_request_tracker;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   drain_pulses = 0;

  memory_request_tracker_if bus ();

  memory_request_tracker dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock and count drain_done pulses seen along the way.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (bus.drain_done) drain_pulses++;
  endtask

  task automatic set_req(input logic v, input logic wr, input logic [7:0] id,
                         input logic [31:0] off, input logic [127:0] data,
                         input logic [127:0] meta);
    bus.req_valid     = v;
    bus.req_cmd_write = wr;
    bus.req_id_buffer = id;
    bus.req_offset    = off;
    bus.req_data      = data;
    bus.req_meta      = meta;
  endtask

  task automatic set_rsp(input logic v, input logic [3:0] tag, input logic [31:0] rdata);
    bus.cache_rsp_valid = v;
    bus.cache_rsp_tag   = tag;
    bus.cache_rsp_rdata = rdata;
  endtask

  task automatic do_cfg();
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  function automatic logic [127:0] mk_fields(input int i);
    logic [31:0] v;
    v = i;
    return {32'h0, 32'h300 + v, 32'h200 + v, 32'h100 + v};
  endfunction

  logic [63:0] bases [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    // base0=0x100, base2=0x1000, base8 near the top for wrap-around
    for (int k = 0; k < 9; k++) bases[k] = 64'(k) * 64'h800;
    bases[0] = 64'h100;
    bases[8] = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int k = 0; k < 9; k++) bus.cfg_base[k*64 +: 64] = bases[k];
    bus.cfg_valid = 1'b0;
    bus.drain_req = 1'b0;
    bus.cache_req_ready = 1'b1;
    bus.mem_rsp_ready   = 1'b1;
    set_req(1'b0, 1'b0, 8'h0, 32'h0, 128'h0, 128'h0);
    set_rsp(1'b0, 4'h0, 32'h0);

    // ---- reset values
    #12;
    check("rst_outstanding", 128'(bus.outstanding), 128'h0);
    check("rst_cache_req_valid", 128'(bus.cache_req_valid), 128'h0);
    check("rst_mem_rsp_valid", 128'(bus.mem_rsp_valid), 128'h0);
    check("rst_drain_done", 128'(bus.drain_done), 128'h0);
    check("rst_err", 128'(bus.err_sticky), 128'h0);
    check("rst_req_ready", 128'(bus.req_ready), 128'h0);
    check("rst_cache_rsp_ready", 128'(bus.cache_rsp_ready), 128'h1);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_req_ready", 128'(bus.req_ready), 128'h0);

    // ---- configure
    do_cfg();
    check("run_req_ready", 128'(bus.req_ready), 128'h1);

    // ---- read via buffer select 0b10 -> base2
    set_req(1'b1, 1'b0, 8'b10, 32'h20, {32'd4, 32'd3, 32'd2, 32'd1},
            128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    tick();
    bus.req_valid = 1'b0;
    check("rd_valid", 128'(bus.cache_req_valid), 128'h1);
    check("rd_addr", 128'(bus.cache_req_addr), 128'h1020);
    check("rd_wstrb", 128'(bus.cache_req_wstrb), 128'h0);
    check("rd_tag", 128'(bus.cache_req_tag), 128'h0);
    check("rd_outstanding", 128'(bus.outstanding), 128'h1);

    // ---- response for tag 0: fields shift up, rdata lands in field 0
    set_rsp(1'b1, 4'd0, 32'h99);
    tick();
    set_rsp(1'b0, 4'd0, 32'h0);
    check("rsp_valid", 128'(bus.mem_rsp_valid), 128'h1);
    check("rsp_data", bus.mem_rsp_data, 128'h00000003_00000002_00000001_00000099);
    check("rsp_meta", bus.mem_rsp_meta, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    check("rsp_outstanding", 128'(bus.outstanding), 128'h0);
    tick();
    check("rsp_consumed", 128'(bus.mem_rsp_valid), 128'h0);

    // ---- writes: multi-bit id -> base0, then zero id -> base0 back-to-back
    set_req(1'b1, 1'b1, 8'b101, 32'h4, 128'hAB, 128'h0);
    tick();
    check("wr_addr", 128'(bus.cache_req_addr), 128'h104);
    check("wr_wstrb", 128'(bus.cache_req_wstrb), 128'hF);
    check("wr_wdata", 128'(bus.cache_req_wdata), 128'hAB);
    check("wr_tag", 128'(bus.cache_req_tag), 128'h0);
    check("wr_outstanding", 128'(bus.outstanding), 128'h0);
    set_req(1'b1, 1'b1, 8'h00, 32'h0, 128'h5A, 128'h0);
    tick();
    check("wr0_addr", 128'(bus.cache_req_addr), 128'h100);
    check("wr0_wdata", 128'(bus.cache_req_wdata), 128'h5A);
    bus.req_valid = 1'b0;
    tick();
    check("wr_drained", 128'(bus.cache_req_valid), 128'h0);

    // ---- address wrap-around, with the cache stalling the request
    bus.cache_req_ready = 1'b0;
    set_req(1'b1, 1'b1, 8'b1000_0000, 32'h20, 128'h77, 128'h0);
    tick();
    bus.req_valid = 1'b0;
    check("wrap_addr", 128'(bus.cache_req_addr), 128'h10);
    check("stall_req_ready", 128'(bus.req_ready), 128'h0);
    tick();
    check("stall_hold_valid", 128'(bus.cache_req_valid), 128'h1);
    check("stall_hold_addr", 128'(bus.cache_req_addr), 128'h10);
    bus.cache_req_ready = 1'b1;
    tick();
    check("stall_release", 128'(bus.cache_req_valid), 128'h0);

    // ---- fill all 16 tags at full throughput
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, 1'b0, 8'b10, 32'(i), mk_fields(i), 128'(i));
      tick();
      check($sformatf("fill_tag%0d", i), 128'(bus.cache_req_tag), 128'(i));
    end
    check("full_outstanding", 128'(bus.outstanding), 128'd16);
    check("full_req_ready", 128'(bus.req_ready), 128'h0);
    set_req(1'b1, 1'b0, 8'b10, 32'h40, mk_fields(32), 128'h20);
    set_rsp(1'b1, 4'd5, 32'h55);
    tick();
    set_rsp(1'b0, 4'd0, 32'h0);
    check("free5_outstanding", 128'(bus.outstanding), 128'd15);
    check("free5_meta", bus.mem_rsp_meta, 128'd5);
    check("free5_data", bus.mem_rsp_data, 128'h00000305_00000205_00000105_00000055);
    check("free5_req_ready", 128'(bus.req_ready), 128'h1);
    tick();
    bus.req_valid = 1'b0;
    check("realloc_tag", 128'(bus.cache_req_tag), 128'd5);
    check("realloc_outstanding", 128'(bus.outstanding), 128'd16);

    // ---- out-of-order responses 2,0,1 while the consumer stalls for 3 cycles
    bus.mem_rsp_ready = 1'b0;
    set_rsp(1'b1, 4'd2, 32'hA2);
    tick();
    check("ooo_first_meta", bus.mem_rsp_meta, 128'd2);
    check("ooo_first_data", bus.mem_rsp_data, 128'h00000302_00000202_00000102_000000A2);
    check("ooo_stall_ready", 128'(bus.cache_rsp_ready), 128'h0);
    set_rsp(1'b1, 4'd0, 32'hA0);
    tick();
    tick();
    check("ooo_hold_meta", bus.mem_rsp_meta, 128'd2);
    check("ooo_hold_outstanding", 128'(bus.outstanding), 128'd15);
    bus.mem_rsp_ready = 1'b1;
    tick();
    check("ooo_second_meta", bus.mem_rsp_meta, 128'd0);
    check("ooo_second_f0", 128'(bus.mem_rsp_data[31:0]), 128'hA0);
    set_rsp(1'b1, 4'd1, 32'hA1);
    tick();
    set_rsp(1'b0, 4'd0, 32'h0);
    check("ooo_third_meta", bus.mem_rsp_meta, 128'd1);
    check("ooo_third_f0", 128'(bus.mem_rsp_data[31:0]), 128'hA1);
    tick();
    check("ooo_done_valid", 128'(bus.mem_rsp_valid), 128'h0);
    check("ooo_outstanding", 128'(bus.outstanding), 128'd13);

    // ---- retire tags 3..12, leaving 13,14,15 in flight
    for (int i = 3; i <= 12; i++) begin
      set_rsp(1'b1, 4'(i), 32'(i));
      tick();
    end
    set_rsp(1'b0, 4'd0, 32'h0);
    tick();
    check("pre_drain_outstanding", 128'(bus.outstanding), 128'd3);

    // ---- drain
    bus.drain_req = 1'b1;
    tick();
    bus.drain_req = 1'b0;
    check("drain_req_ready", 128'(bus.req_ready), 128'h0);
    set_rsp(1'b1, 4'd7, 32'hBAD);
    tick();
    set_rsp(1'b0, 4'd0, 32'h0);
    check("bogus_err", 128'(bus.err_sticky), 128'h1);
    check("bogus_no_output", 128'(bus.mem_rsp_valid), 128'h0);
    check("bogus_outstanding", 128'(bus.outstanding), 128'd3);
    for (int i = 13; i <= 15; i++) begin
      set_rsp(1'b1, 4'(i), 32'(i));
      tick();
    end
    set_rsp(1'b0, 4'd0, 32'h0);
    check("last_rsp_meta", bus.mem_rsp_meta, 128'd15);
    check("no_early_drain", 128'(drain_pulses), 128'd0);
    tick();
    tick();
    tick();
    check("drain_pulses", 128'(drain_pulses), 128'd1);
    check("post_drain_req_ready", 128'(bus.req_ready), 128'h0);
    check("err_still_set", 128'(bus.err_sticky), 128'h1);

    // ---- reconfigure; simultaneous allocate and free
    do_cfg();
    set_req(1'b1, 1'b0, 8'b10, 32'h0, mk_fields(40), 128'h40);
    tick();
    check("sim_first_tag", 128'(bus.cache_req_tag), 128'd0);
    set_req(1'b1, 1'b0, 8'b10, 32'h4, mk_fields(41), 128'h41);
    set_rsp(1'b1, 4'd0, 32'hC0);
    tick();
    bus.req_valid = 1'b0;
    set_rsp(1'b0, 4'd0, 32'h0);
    check("sim_second_tag", 128'(bus.cache_req_tag), 128'd1);
    check("sim_outstanding", 128'(bus.outstanding), 128'd1);
    check("sim_rsp_meta", bus.mem_rsp_meta, 128'h40);

    // ---- reset mid-operation discards everything
    ap_rst_n = 1'b0;
    #2;
    check("midrst_outstanding", 128'(bus.outstanding), 128'h0);
    check("midrst_err", 128'(bus.err_sticky), 128'h0);
    check("midrst_cache_req_valid", 128'(bus.cache_req_valid), 128'h0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    tick(); tick(); tick();
    check("midrst_needs_cfg", 128'(bus.req_ready), 128'h0);
    do_cfg();
    check("recfg_req_ready", 128'(bus.req_ready), 128'h1);
    check("recfg_err_clear", 128'(bus.err_sticky), 128'h0);
    do_cfg();
    check("cfg_in_run_err", 128'(bus.err_sticky), 128'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
